booth_radix4_mult: RTL and testbench

Parametrised sequential radix-4 (modified) Booth multiplier. It is the next generation of the team's radix-2 Booth core. It adds a generic operand width, a per-operation signed/unsigned mode, and a two-bits-per-cycle recode that halves the iteration count. It sits as a multi-cycle arithmetic unit behind a start/ready handshake, and the result is held stable until the next operation is accepted.

---
 rtl/booth_radix4_mult.sv | 120 ++++++++++++
 tb/tb_booth_radix4_mult.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 (modified) Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed or unsigned per operation; one 2-bit recode step per cycle behind a start/ready handshake.
module booth_radix4_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int W2 = WIDTH + 2;
   localparam int N  = W2 / 2;
   localparam int AW = W2 + 2;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      a_q, a_d;
   logic [W2-1:0]      q_q, q_d;
   logic               q1_q, q1_d;
   logic [W2-1:0]      mx_q, mx_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;

   logic [AW-1:0]      mx_ext, mx2_ext, addend, sum, a_next;
   logic [W2-1:0]      q_next;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case can infer a latch.
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      q1_d      = q1_q;
      mx_d      = mx_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      mx_ext  = {{2{mx_q[W2-1]}}, mx_q};
      mx2_ext = mx_ext << 1;
      unique case ({q_q[1], q_q[0], q1_q})
         3'b001, 3'b010: addend = mx_ext;
         3'b011:         addend = mx2_ext;
         3'b100:         addend = ~mx2_ext + AW'(1);
         3'b101, 3'b110: addend = ~mx_ext + AW'(1);
         default:        addend = '0;
      endcase
      sum    = a_q + addend;
      // {A,Q,q_1} arithmetic shift right by two, A's sign replicated
      a_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_next = {sum[1:0], q_q[W2-1:2]};

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mx_d    = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
               q_d     = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
               a_d     = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_next;
            q_d   = q_next;
            q1_d  = q_q[1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d   = DONE;
               product_d = {a_next[WIDTH-3:0], q_next};
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d == RUN);
      ready_d = (state_d == DONE);
   end

   // NOTE: state and outputs use non-blocking assignments; the datapath is reset too so a reset mid-run leaves no stale partial product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         mx_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         mx_q      <= mx_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign busy    = busy_q;
   assign ready   = ready_q;
   assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult at WIDTH 4, 8 and 16; expected products come from
// plain integer multiplication of the sampled operands.
module tb_booth_radix4_mult;

   localparam int N4  = 3;
   localparam int N8  = 5;
   localparam int N16 = 9;

   typedef struct {
      logic [31:0] exp;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst, rst_o;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic        start8, sm8, busy8, ready8;
   logic [7:0]  mc8, mp8;
   logic [15:0] product8;
   logic        start4, sm4, busy4, ready4;
   logic [3:0]  mc4, mp4;
   logic [7:0]  product4;
   logic        start16, sm16, busy16, ready16;
   logic [15:0] mc16, mp16;
   logic [31:0] product16;

   exp_t q4[$], q8[$], q16[$];

   booth_radix4_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .multiplicand(mc8), .multiplier(mp8),
      .busy(busy8), .ready(ready8), .product(product8));

   booth_radix4_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst_o), .start(start4), .signed_mode(sm4),
      .multiplicand(mc4), .multiplier(mp4),
      .busy(busy4), .ready(ready4), .product(product4));

   booth_radix4_mult #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst_o), .start(start16), .signed_mode(sm16),
      .multiplicand(mc16), .multiplier(mp16),
      .busy(busy16), .ready(ready16), .product(product16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: interpret the w-bit operands as signed or unsigned integers and multiply.
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] m, input logic [15:0] q,
                                           input bit s);
      longint mask, mv, qv, p;
      mask = (longint'(1) << w) - 1;
      mv   = longint'(m) & mask;
      qv   = longint'(q) & mask;
      if (s && mv[w-1]) mv = mv - (longint'(1) << w);
      if (s && qv[w-1]) qv = qv - (longint'(1) << w);
      p = (mv * qv) & ((longint'(1) << (2 * w)) - 1);
      return p[31:0];
   endfunction

   // ---------------- monitors ----------------
   logic [15:0] last8;
   logic [7:0]  last4;
   logic [31:0] last16;
   logic        prev8, prev4, prev16;

   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst) begin
         last8 = '0;
         prev8 = 1'b0;
      end else begin
         if (ready8) begin
            check("ready8_one_cycle", 32'(prev8), 32'd0);
            if (q8.size() == 0) check("ready8_unexpected", 32'd1, 32'd0);
            else begin
               e = q8.pop_front();
               check("product8", 32'(product8), e.exp);
               check("latency8", 32'(cyc - e.cyc), 32'(N8 + 1));
            end
            last8 = product8;
         end else begin
            check("product8_hold", 32'(product8), 32'(last8));
         end
         prev8 = ready8;
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (rst_o) begin
         last4 = '0;
         prev4 = 1'b0;
      end else begin
         if (ready4) begin
            check("ready4_one_cycle", 32'(prev4), 32'd0);
            if (q4.size() == 0) check("ready4_unexpected", 32'd1, 32'd0);
            else begin
               e = q4.pop_front();
               check("product4", 32'(product4), e.exp);
               check("latency4", 32'(cyc - e.cyc), 32'(N4 + 1));
            end
            last4 = product4;
         end else begin
            check("product4_hold", 32'(product4), 32'(last4));
         end
         prev4 = ready4;
      end
   end

   always @(negedge clk) begin : mon16
      exp_t e;
      if (rst_o) begin
         last16 = '0;
         prev16 = 1'b0;
      end else begin
         if (ready16) begin
            check("ready16_one_cycle", 32'(prev16), 32'd0);
            if (q16.size() == 0) check("ready16_unexpected", 32'd1, 32'd0);
            else begin
               e = q16.pop_front();
               check("product16", product16, e.exp);
               check("latency16", 32'(cyc - e.cyc), 32'(N16 + 1));
            end
            last16 = product16;
         end else begin
            check("product16_hold", product16, last16);
         end
         prev16 = ready16;
      end
   end

   // ---------------- WIDTH=8 stimulus ----------------
   // Issue one operation, then drive N cycles of inputs the DUT must ignore while running.
   task automatic op8(input bit s, input logic [7:0] m, input logic [7:0] q,
                      input logic [31:0] exp, input bit hold_start);
      start8 = 1'b1; sm8 = s; mc8 = m; mp8 = q;
      q8.push_back('{exp, cyc});
      @(posedge clk); #1;
      check("busy8_after_start", 32'(busy8), 32'd1);
      for (int i = 0; i < N8; i++) begin
         start8 = hold_start ? 1'b1 : 1'($urandom_range(1));
         sm8    = 1'($urandom_range(1));
         mc8    = 8'($urandom);
         mp8    = 8'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle8(input int n);
      start8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rand_op8(input bit hold_start);
      logic [7:0] m, q;
      bit s;
      m = 8'($urandom); q = 8'($urandom); s = 1'($urandom_range(1));
      op8(s, m, q, ref_mul(8, 16'(m), 16'(q), s), hold_start);
   endtask

   // ---------------- WIDTH=4 / WIDTH=16 stimulus ----------------
   task automatic run4();
      for (int s = 0; s < 2; s++)
         for (int m = 0; m < 16; m++)
            for (int q = 0; q < 16; q++) begin
               start4 = 1'b1; sm4 = 1'(s); mc4 = 4'(m); mp4 = 4'(q);
               q4.push_back('{ref_mul(4, 16'(m), 16'(q), 1'(s)), cyc});
               @(posedge clk); #1;
               repeat (N4) begin
                  start4 = 1'($urandom_range(1)); sm4 = 1'($urandom_range(1));
                  mc4 = 4'($urandom); mp4 = 4'($urandom);
                  @(posedge clk); #1;
               end
            end
      start4 = 1'b0;
   endtask

   task automatic run16(input int n_ops);
      logic [15:0] m, q;
      bit s;
      repeat (n_ops) begin
         m = 16'($urandom); q = 16'($urandom); s = 1'($urandom_range(1));
         start16 = 1'b1; sm16 = s; mc16 = m; mp16 = q;
         q16.push_back('{ref_mul(16, m, q, s), cyc});
         @(posedge clk); #1;
         repeat (N16) begin
            start16 = 1'($urandom_range(1)); sm16 = 1'($urandom_range(1));
            mc16 = 16'($urandom); mp16 = 16'($urandom);
            @(posedge clk); #1;
         end
         if ($urandom_range(3) == 0) begin
            start16 = 1'b0;
            @(posedge clk); #1;
         end
      end
      start16 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst_o = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
      start4 = 1'b0; sm4 = 1'b0; mc4 = '0; mp4 = '0;
      start16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
      #12;
      check("reset_busy8", 32'(busy8), 32'd0);
      check("reset_ready8", 32'(ready8), 32'd0);
      check("reset_product8", 32'(product8), 32'd0);
      check("reset_product16", product16, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; rst_o = 1'b0;
      idle8(1);

      // Directed corner cases with the required results written out.
      op8(1'b0, 8'hFF, 8'hFF, 32'h0000_FE01, 1'b0);
      idle8(2);
      op8(1'b1, 8'h80, 8'h80, 32'h0000_4000, 1'b0);
      op8(1'b1, 8'h80, 8'h7F, 32'h0000_C080, 1'b0);
      idle8(1);
      op8(1'b0, 8'hFB, 8'h06, 32'h0000_05E2, 1'b0);
      op8(1'b1, 8'hFB, 8'h06, 32'h0000_FFE2, 1'b0);
      idle8(1);

      // Reset two cycles into a run: outputs must clear without waiting for a clock edge.
      start8 = 1'b1; sm8 = 1'b1; mc8 = 8'h06; mp8 = 8'hFB;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy8_before_abort", 32'(busy8), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_busy8", 32'(busy8), 32'd0);
      check("abort_ready8", 32'(ready8), 32'd0);
      check("abort_product8", 32'(product8), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      op8(1'b1, 8'h06, 8'hFB, 32'h0000_FFE2, 1'b0);
      idle8(1);

      // start held high with operands changing every cycle.
      repeat (8) rand_op8(1'b1);
      idle8(1);

      repeat (200) begin
         rand_op8(1'($urandom_range(1)));
         if ($urandom_range(2) == 0) idle8($urandom_range(3, 1));
      end
      idle8(2);

      fork
         run4();
         run16(2000);
      join

      for (int i = 0; i < 100 && (q4.size() + q8.size() + q16.size()) != 0; i++) begin
         @(posedge clk); #1;
      end
      check("scoreboard_drained", 32'(q4.size() + q8.size() + q16.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
